// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory: access-size codes and
// the byte-enable decode used by the store path.
package mem_pkg;

  localparam logic [1:0] MEM_WORD = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_BYTE = 2'b10;
  localparam logic [1:0] MEM_BAD  = 2'b11;

  // Little-endian: byte lane 0 is bits [7:0]; an illegal size enables no lanes.
  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      MEM_WORD: be = 4'b1111;
      MEM_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      MEM_BYTE: be = 4'b0001 << addr;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_memory_stage_load_align.sv
// Load lane extraction: selects the addressed half/byte of a memory word and
// sign- or zero-extends it to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
  assign w_byte = i_word[{i_addr, 3'b000} +: 8];

  always_comb begin
    o_data = '0;
    case (i_size)
      MEM_WORD: o_data = i_word;
      MEM_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      MEM_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      default:  o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_stage.sv
// MEM-stage data memory: combinational-read, byte-enabled synchronous-write
// array with bad-access suppression and a sticky first-fault record.
module data_memory_stage
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  output logic [31:0] ReadData,
  output logic        Fault,
  output logic [31:0] FaultAddr
);

  logic [31:0] r_mem [0:DEPTH_WORDS-1];
  logic        r_fault;
  logic [31:0] r_fault_addr;

  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_word;
  logic [31:0]       w_load;
  logic [31:0]       w_wdata_rep;
  logic [31:0]       w_merged;
  logic [3:0]        w_be;
  logic              w_access;
  logic              w_bad;
  logic              w_we;

  assign w_idx    = Address[ADDR_W+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_access = MemRead | MemWrite;

  assign w_bad = w_access & ((MemSize == MEM_BAD)
                           | ((MemSize == MEM_HALF) & Address[0])
                           | ((MemSize == MEM_WORD) & (Address[1:0] != 2'b00))
                           | (|Address[31:ADDR_W+2]));

  load_align u_load_align (
    .i_word     (w_word),
    .i_addr     (Address[1:0]),
    .i_size     (MemSize),
    .i_unsigned (MemUnsigned),
    .o_data     (w_load)
  );

  assign ReadData = (!reset && MemRead && !w_bad) ? w_load : 32'h0;

  // Sub-word store data is replicated across lanes so the enable alone picks the slot.
  always_comb begin
    w_wdata_rep = WriteData;
    case (MemSize)
      MEM_HALF: w_wdata_rep = {2{WriteData[15:0]}};
      MEM_BYTE: w_wdata_rep = {4{WriteData[7:0]}};
      default:  w_wdata_rep = WriteData;
    endcase
  end

  assign w_be = be_of(MemSize, Address[1:0]);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_merged[8*gi +: 8] = w_be[gi] ? w_wdata_rep[8*gi +: 8] : w_word[8*gi +: 8];
    end
  endgenerate

  assign w_we = !reset && MemWrite && !w_bad;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault      <= 1'b0;
      r_fault_addr <= 32'h0;
    end else if (w_bad && !r_fault) begin
      r_fault      <= 1'b1;
      r_fault_addr <= Address;
    end
  end

  assign Fault     = r_fault;
  assign FaultAddr = r_fault_addr;

endmodule

// File: tb/tb_data_memory_stage.sv
// Self-checking bench for data_memory_stage: a vector table for the load/store
// datapath plus hand-written fault and reset sequences, checked via a scoreboard queue.
module tb_data_memory_stage;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemUnsigned;
  logic [31:0] ReadData;
  logic        Fault;
  logic [31:0] FaultAddr;

  int pass_cnt;
  int total_cnt;

  logic [31:0] sb_q[$];

  typedef struct {
    logic [63:0] name;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  data_memory_stage #(.DEPTH_WORDS(1024), .ADDR_W(10), .INIT_FILE("")) dut (
    .clk         (clk),
    .reset       (reset),
    .Address     (Address),
    .WriteData   (WriteData),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemSize     (MemSize),
    .MemUnsigned (MemUnsigned),
    .ReadData    (ReadData),
    .Fault       (Fault),
    .FaultAddr   (FaultAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input logic [63:0] name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s act=%08h exp=%08h", name, act, exp);
    end else begin
      $display("FAIL %s act=%08h exp=%08h", name, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, score ReadData mid-cycle; the following posedge commits.
  task automatic apply(input logic [63:0] name, input logic [31:0] addr, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] exp);
    logic [31:0] e;
    @(negedge clk);
    Address     = addr;
    WriteData   = wd;
    MemRead     = rd;
    MemWrite    = wr;
    MemSize     = size;
    MemUnsigned = uns;
    sb_q.push_back(exp);
    #1;
    e = sb_q.pop_front();
    check32(name, ReadData, e);
  endtask

  task automatic check_fault(input logic [63:0] name, input logic exp_f, input logic [31:0] exp_a);
    @(posedge clk);
    #1;
    check32(name, {31'h0, Fault}, {31'h0, exp_f});
    check32(name, FaultAddr, exp_a);
  endtask

  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    reset       = 1'b1;
    Address     = 32'h0;
    WriteData   = 32'h0;
    MemRead     = 1'b1;
    MemWrite    = 1'b0;
    MemSize     = MEM_WORD;
    MemUnsigned = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_f", {31'h0, Fault}, 32'h0);
    check32("rst_fa", FaultAddr, 32'h0);
    check32("rst_rd", ReadData, 32'h0);
    reset = 1'b0;

    // name, addr, wdata, rd, wr, size, uns, expected ReadData
    vecs.push_back('{"sw10",   32'h10, 32'h11223344, 1'b0, 1'b1, MEM_WORD, 1'b0, 32'h0});
    vecs.push_back('{"lw10",   32'h10, 32'h0,        1'b1, 1'b0, MEM_WORD, 1'b0, 32'h11223344});
    vecs.push_back('{"lh12",   32'h12, 32'h0,        1'b1, 1'b0, MEM_HALF, 1'b0, 32'h00001122});
    vecs.push_back('{"lh10",   32'h10, 32'h0,        1'b1, 1'b0, MEM_HALF, 1'b0, 32'h00003344});
    vecs.push_back('{"lb13",   32'h13, 32'h0,        1'b1, 1'b0, MEM_BYTE, 1'b0, 32'h00000011});
    vecs.push_back('{"lb10",   32'h10, 32'h0,        1'b1, 1'b0, MEM_BYTE, 1'b0, 32'h00000044});
    vecs.push_back('{"lbu11",  32'h11, 32'h0,        1'b1, 1'b0, MEM_BYTE, 1'b1, 32'h00000033});
    vecs.push_back('{"sw20",   32'h20, 32'hAABBCCDD, 1'b0, 1'b1, MEM_WORD, 1'b0, 32'h0});
    vecs.push_back('{"sb21",   32'h21, 32'h123456F0, 1'b0, 1'b1, MEM_BYTE, 1'b0, 32'h0});
    vecs.push_back('{"lw20",   32'h20, 32'h0,        1'b1, 1'b0, MEM_WORD, 1'b0, 32'hAABBF0DD});
    vecs.push_back('{"lb21",   32'h21, 32'h0,        1'b1, 1'b0, MEM_BYTE, 1'b0, 32'hFFFFFFF0});
    vecs.push_back('{"lbu21",  32'h21, 32'h0,        1'b1, 1'b0, MEM_BYTE, 1'b1, 32'h000000F0});
    vecs.push_back('{"sh22",   32'h22, 32'hDEAD8765, 1'b0, 1'b1, MEM_HALF, 1'b0, 32'h0});
    vecs.push_back('{"lw20b",  32'h20, 32'h0,        1'b1, 1'b0, MEM_WORD, 1'b0, 32'h8765F0DD});
    vecs.push_back('{"lh22",   32'h22, 32'h0,        1'b1, 1'b0, MEM_HALF, 1'b0, 32'hFFFF8765});
    vecs.push_back('{"lhu22",  32'h22, 32'h0,        1'b1, 1'b0, MEM_HALF, 1'b1, 32'h00008765});
    vecs.push_back('{"sw40",   32'h40, 32'h00000001, 1'b0, 1'b1, MEM_WORD, 1'b0, 32'h0});
    vecs.push_back('{"rw40",   32'h40, 32'h00000002, 1'b1, 1'b1, MEM_WORD, 1'b0, 32'h00000001});
    vecs.push_back('{"lw40",   32'h40, 32'h0,        1'b1, 1'b0, MEM_WORD, 1'b0, 32'h00000002});
    vecs.push_back('{"idle",   32'h10, 32'hFFFFFFFF, 1'b0, 1'b0, MEM_WORD, 1'b0, 32'h0});
    vecs.push_back('{"lw10b",  32'h10, 32'h0,        1'b1, 1'b0, MEM_WORD, 1'b0, 32'h11223344});

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].wr,
            vecs[i].size, vecs[i].uns, vecs[i].exp);
    check_fault("nofault", 1'b0, 32'h0);

    // Misaligned word store: suppressed, first fault recorded, later faults ignored.
    apply("sw04",   32'h4, 32'hCAFEBABE, 1'b0, 1'b1, MEM_WORD, 1'b0, 32'h0);
    apply("sw06bad", 32'h6, 32'hDEADBEEF, 1'b0, 1'b1, MEM_WORD, 1'b0, 32'h0);
    check_fault("flt06", 1'b1, 32'h6);
    apply("lw04",   32'h4, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 32'hCAFEBABE);
    apply("lw06bad", 32'h6, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0);
    apply("lh07bad", 32'h7, 32'h0, 1'b1, 1'b0, MEM_HALF, 1'b0, 32'h0);
    apply("sz11bad", 32'h4, 32'h0, 1'b1, 1'b0, MEM_BAD,  1'b0, 32'h0);
    check_fault("flt07", 1'b1, 32'h6);

    // Out-of-range address aliasing word 0 must not read or write it.
    reset = 1'b1;
    apply("rstrd",  32'h4, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0);
    check_fault("rstclr", 1'b0, 32'h0);
    reset = 1'b0;
    apply("sw00",   32'h0, 32'h13579BDF, 1'b0, 1'b1, MEM_WORD, 1'b0, 32'h0);
    apply("lwoor",  32'h0001_0000, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0);
    check_fault("fltoor", 1'b1, 32'h0001_0000);
    apply("swoor",  32'h0001_0000, 32'hFFFFFFFF, 1'b0, 1'b1, MEM_WORD, 1'b0, 32'h0);
    apply("lw00",   32'h0, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h13579BDF);

    // Store in a reset cycle is dropped and the fault record clears.
    apply("sw80",   32'h80, 32'h00000077, 1'b0, 1'b1, MEM_WORD, 1'b0, 32'h0);
    apply("lb03bad", 32'h3, 32'h0, 1'b1, 1'b0, MEM_BAD, 1'b0, 32'h0);
    check_fault("flt03", 1'b1, 32'h0001_0000);
    reset = 1'b1;
    apply("rstsw80", 32'h80, 32'h00000055, 1'b1, 1'b1, MEM_WORD, 1'b0, 32'h0);
    check_fault("rstmid", 1'b0, 32'h0);
    reset = 1'b0;
    apply("lw80",   32'h80, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h00000077);
    check_fault("after", 1'b0, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
